// File: rtl/avalon_timer_pkg.sv
// Shared definitions for the parametrised Avalon-MM interval timer.
// Holds the register offsets, the CONTROL/STATUS bit positions and the
// run/stop state encoding used by the top level.
package avalon_timer_pkg;

    localparam int unsigned ADDR_W = 3;

    // Word offsets on the Avalon slave port
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIODL = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PERIODH = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_SNAPL   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_SNAPH   = 3'd5;

    // STATUS bits
    localparam int unsigned BIT_TO    = 0;
    localparam int unsigned BIT_RUN   = 1;

    // CONTROL bits
    localparam int unsigned BIT_ITO   = 0;
    localparam int unsigned BIT_CONT  = 1;
    localparam int unsigned BIT_START = 2;
    localparam int unsigned BIT_STOP  = 3;

    // Counter run state
    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } run_state_e;

endpackage

// File: rtl/avalon_interval_timer_timer_count_core.sv
// Down-counter core of the interval timer.
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   i_run            : counter decrements while high
//   i_force_reload   : load i_period this clock (a period register was written)
//   i_period         : reload value
//   o_count          : current counter value (registered)
//   o_timeout_c      : combinational, high in the clock the counter sits at 0 while running
module timer_count_core #(
    parameter int unsigned         COUNT_W     = 32,
    parameter logic [COUNT_W-1:0]  RESET_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic               i_force_reload,
    input  logic [COUNT_W-1:0] i_period,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_timeout_c
);

    logic [COUNT_W-1:0] r_count;
    logic               w_zero;

    assign w_zero      = (r_count == '0);
    assign o_timeout_c = i_run & w_zero;
    assign o_count     = r_count;

    // Forced load beats timeout reload beats decrement; 0 never decrements
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= RESET_VALUE;
        end else if (i_force_reload) begin
            r_count <= i_period;
        end else if (o_timeout_c) begin
            r_count <= i_period;
        end else if (i_run) begin
            r_count <= r_count - COUNT_W'(1);
        end
    end

endmodule

// File: rtl/avalon_interval_timer_param.sv
// Parametrised Avalon-MM interval timer with runtime period, start/stop,
// continuous/one-shot mode, counter snapshot and a level IRQ.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   address      : word address (STATUS, CONTROL, PERIODL/H, SNAPL/H)
//   chipselect   : slave select
//   write_n      : active-low write strobe
//   writedata    : write data
//   readdata     : registered read mux, one clock latency, updated every clock
//   irq          : TO & ITO
module avalon_interval_timer_param
    import avalon_timer_pkg::*;
#(
    parameter int unsigned     DATA_W       = 16,
    parameter int unsigned     COUNT_W      = 32,
    parameter longint unsigned RESET_PERIOD = 62499,
    parameter bit              ALWAYS_RUN   = 1'b0,
    parameter bit              RESET_CONT   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    localparam int unsigned        HI_W       = COUNT_W - DATA_W;
    localparam logic [COUNT_W-1:0] RESET_LOAD = COUNT_W'(RESET_PERIOD);
    localparam run_state_e         RESET_ST   = ALWAYS_RUN ? ST_RUNNING : ST_STOPPED;

    run_state_e         r_state;
    run_state_e         w_state_next;
    logic               r_to;
    logic               r_ito;
    logic               r_cont;
    logic [COUNT_W-1:0] r_period;
    logic [COUNT_W-1:0] r_snap;
    logic               r_force_reload;
    logic [DATA_W-1:0]  r_readdata;

    logic               w_wr;
    logic               w_wr_status;
    logic               w_wr_ctrl;
    logic               w_wr_perl;
    logic               w_wr_perh;
    logic               w_wr_snap;
    logic               w_start;
    logic               w_stop;
    logic               w_run;
    logic               w_timeout_c;
    logic [COUNT_W-1:0] w_count;
    logic [DATA_W-1:0]  w_rd_mux;

    // Avalon write decode
    assign w_wr        = chipselect & ~write_n;
    assign w_wr_status = w_wr & (address == ADDR_STATUS);
    assign w_wr_ctrl   = w_wr & (address == ADDR_CONTROL);
    assign w_wr_perl   = w_wr & (address == ADDR_PERIODL);
    assign w_wr_perh   = w_wr & (address == ADDR_PERIODH);
    assign w_wr_snap   = w_wr & ((address == ADDR_SNAPL) | (address == ADDR_SNAPH));
    assign w_start     = w_wr_ctrl & writedata[BIT_START];
    assign w_stop      = w_wr_ctrl & writedata[BIT_STOP] & !ALWAYS_RUN;

    assign w_run    = (r_state == ST_RUNNING);
    assign irq      = r_to & r_ito;
    assign readdata = r_readdata;

    timer_count_core #(
        .COUNT_W     (COUNT_W),
        .RESET_VALUE (RESET_LOAD)
    ) u_core (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_run          (w_run),
        .i_force_reload (r_force_reload),
        .i_period       (r_period),
        .o_count        (w_count),
        .o_timeout_c    (w_timeout_c)
    );

    // Run state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RESET_ST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Run state next: STOP beats START, one-shot timeout stops the counter
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_STOPPED: begin
                if (w_start && !w_stop) begin
                    w_state_next = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (w_stop || (w_timeout_c && !r_cont)) begin
                    w_state_next = ST_STOPPED;
                end
            end
            default: w_state_next = RESET_ST;
        endcase
    end

    // Control, status, period and snapshot registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_to           <= 1'b0;
            r_ito          <= 1'b0;
            r_cont         <= RESET_CONT;
            r_period       <= RESET_LOAD;
            r_snap         <= '0;
            r_force_reload <= 1'b0;
        end else begin
            // A timeout in the same clock as a STATUS write keeps TO set
            if (w_timeout_c) begin
                r_to <= 1'b1;
            end else if (w_wr_status) begin
                r_to <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_ito  <= writedata[BIT_ITO];
                r_cont <= writedata[BIT_CONT];
            end
            if (w_wr_perl) begin
                r_period[DATA_W-1:0] <= writedata;
            end
            if (w_wr_perh) begin
                r_period[COUNT_W-1:DATA_W] <= writedata[HI_W-1:0];
            end
            if (w_wr_snap) begin
                r_snap <= w_count;
            end
            // The counter picks up the new period one clock after the write
            r_force_reload <= w_wr_perl | w_wr_perh;
        end
    end

    // Read mux
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_STATUS: begin
                w_rd_mux[BIT_RUN] = w_run;
                w_rd_mux[BIT_TO]  = r_to;
            end
            ADDR_CONTROL: begin
                w_rd_mux[BIT_CONT] = r_cont;
                w_rd_mux[BIT_ITO]  = r_ito;
            end
            ADDR_PERIODL: w_rd_mux = r_period[DATA_W-1:0];
            ADDR_PERIODH: w_rd_mux = DATA_W'(r_period[COUNT_W-1:DATA_W]);
            ADDR_SNAPL:   w_rd_mux = r_snap[DATA_W-1:0];
            ADDR_SNAPH:   w_rd_mux = DATA_W'(r_snap[COUNT_W-1:DATA_W]);
            default:      w_rd_mux = '0;
        endcase
    end

    // Registered read data, independent of chipselect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

endmodule

// File: tb/tb_avalon_interval_timer_param.sv
// Bench for avalon_interval_timer_param: a register-level reference model
// predicts readdata and irq for every clock, expectations go into a queue and
// a monitor compares them after each rising edge. Directed sequences add
// hand-derived constant expectations on top of the model.
module tb_avalon_interval_timer_param;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned COUNT_W = 32;
    localparam logic [31:0] RP = 32'd299;
    localparam bit ALWAYS_RUN = 1'b0;
    localparam bit RESET_CONT = 1'b1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'h0;
    logic [15:0] readdata;
    logic        irq;

    avalon_interval_timer_param #(
        .DATA_W       (DATA_W),
        .COUNT_W      (COUNT_W),
        .RESET_PERIOD (64'(RP)),
        .ALWAYS_RUN   (ALWAYS_RUN),
        .RESET_CONT   (RESET_CONT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rd;
        logic        irq;
        logic        dr;
        logic [15:0] drv;
        logic        di;
        logic        div;
        logic [7:0]  phase;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Directed expectation attached to the next issued cycle
    logic        dir_rd_en = 1'b0;
    logic [15:0] dir_rd_val = 16'h0;
    logic        dir_irq_en = 1'b0;
    logic        dir_irq_val = 1'b0;
    logic [7:0]  phase = 8'd0;

    // Reference model: timer registers as seen by software
    logic [31:0] m_count;
    logic [31:0] m_period;
    logic [31:0] m_snap;
    logic        m_run, m_to, m_ito, m_cont, m_force;

    function automatic logic [15:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: model_read = {14'h0, m_run, m_to};
            3'd1: model_read = {14'h0, m_cont, m_ito};
            3'd2: model_read = m_period[15:0];
            3'd3: model_read = m_period[31:16];
            3'd4: model_read = m_snap[15:0];
            3'd5: model_read = m_snap[31:16];
            default: model_read = 16'h0;
        endcase
    endfunction

    // Advance the model by one rising edge; returns what the DUT shows after it
    task automatic model_step(input bit rn, input bit cs, input bit wn,
                              input logic [2:0] a, input logic [15:0] wd,
                              output logic [15:0] erd, output logic eirq);
        bit          wr, fire;
        logic [31:0] n_count;
        logic        n_run, n_to;
        if (!rn) begin
            m_count = RP; m_period = RP; m_snap = 32'h0;
            m_run = ALWAYS_RUN; m_to = 1'b0; m_ito = 1'b0; m_cont = RESET_CONT; m_force = 1'b0;
            erd = 16'h0; eirq = 1'b0;
        end else begin
            erd  = model_read(a);
            wr   = cs && !wn;
            fire = m_run && (m_count == 32'h0);
            // period loads (pending write or timeout) beat counting down
            n_count = (m_force || fire) ? m_period : (m_run ? m_count - 32'h1 : m_count);
            n_run = m_run;
            if (fire && !m_cont) n_run = 1'b0;
            if (wr && a == 3'd1) begin
                if (wd[3] && !ALWAYS_RUN) n_run = 1'b0;
                else if (wd[2] && !m_run) n_run = 1'b1;
            end
            n_to = m_to;
            if (wr && a == 3'd0) n_to = 1'b0;
            if (fire) n_to = 1'b1;
            if (wr && (a == 3'd4 || a == 3'd5)) m_snap = m_count;
            if (wr && a == 3'd1) begin m_ito = wd[0]; m_cont = wd[1]; end
            if (wr && a == 3'd2) m_period[15:0] = wd;
            if (wr && a == 3'd3) m_period[31:16] = wd;
            m_force = wr && (a == 3'd2 || a == 3'd3);
            m_count = n_count; m_run = n_run; m_to = n_to;
            eirq = m_to & m_ito;
        end
    endtask

    task automatic cycle(input bit rn, input bit cs, input bit wn,
                         input logic [2:0] a, input logic [15:0] wd);
        exp_t e;
        @(negedge clk);
        reset_n = rn; chipselect = cs; write_n = wn; address = a; writedata = wd;
        model_step(rn, cs, wn, a, wd, e.rd, e.irq);
        e.dr = dir_rd_en; e.drv = dir_rd_val;
        e.di = dir_irq_en; e.div = dir_irq_val;
        e.phase = phase;
        dir_rd_en = 1'b0; dir_irq_en = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b1, 3'd0, 16'h0);
    endtask
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cycle(1'b1, 1'b1, 1'b0, a, d);
    endtask
    task automatic rd(input logic [2:0] a);
        cycle(1'b1, 1'b1, 1'b1, a, 16'h0);
    endtask
    task automatic exp_rd(input logic [15:0] v);
        dir_rd_en = 1'b1; dir_rd_val = v;
    endtask
    task automatic exp_irq(input logic v);
        dir_irq_en = 1'b1; dir_irq_val = v;
    endtask

    // Idle until the model counter reaches v while running
    task automatic wait_count(input logic [31:0] v);
        int g = 0;
        while (!(m_run && m_count == v) && g < 2000) begin
            idle(1);
            g++;
        end
        if (g >= 2000) begin
            n_checks++; n_fail++;
            $display("FAIL wait_count phase %0d: counter never reached %0d", phase, v);
        end
    endtask

    // Monitor: compare the DUT outputs after every rising edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (readdata !== e.rd) begin
                n_fail++;
                $display("FAIL readdata phase %0d t=%0t: got %h, expected %h", e.phase, $time, readdata, e.rd);
            end
            n_checks++;
            if (irq !== e.irq) begin
                n_fail++;
                $display("FAIL irq phase %0d t=%0t: got %b, expected %b", e.phase, $time, irq, e.irq);
            end
            if (e.dr) begin
                n_checks++;
                if (readdata !== e.drv) begin
                    n_fail++;
                    $display("FAIL directed_rd phase %0d t=%0t: got %h, expected %h", e.phase, $time, readdata, e.drv);
                end
            end
            if (e.di) begin
                n_checks++;
                if (irq !== e.div) begin
                    n_fail++;
                    $display("FAIL directed_irq phase %0d t=%0t: got %b, expected %b", e.phase, $time, irq, e.div);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        phase = 8'd1;
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
        exp_rd(16'h0); exp_irq(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
        exp_rd(16'h0); idle(1);
        exp_rd(16'd299); rd(3'd2);
        exp_rd(16'h0); rd(3'd3);
        exp_rd(16'h2); rd(3'd1);
        wr(3'd4, 16'h0);
        exp_rd(16'd299); rd(3'd4);

        // Continuous run: TO exactly 300 clocks after start, irq once ITO set
        phase = 8'd2;
        wr(3'd1, 16'h6);
        idle(299);
        exp_rd(16'h2); idle(1);
        exp_rd(16'h3); exp_irq(1'b0); idle(1);
        exp_irq(1'b1); wr(3'd1, 16'h3);
        exp_irq(1'b0); wr(3'd0, 16'h0);

        // STATUS write coinciding with a timeout, then a clean clear
        phase = 8'd3;
        wait_count(32'h0);
        exp_irq(1'b1); wr(3'd0, 16'h0);
        exp_rd(16'h3); idle(1);
        exp_irq(1'b0); wr(3'd0, 16'h0);
        exp_rd(16'h2); idle(1);

        // One-shot with period 9
        phase = 8'd4;
        wr(3'd1, 16'h8);
        wr(3'd0, 16'h0);
        wr(3'd2, 16'd9);
        wr(3'd3, 16'h0);
        wr(3'd1, 16'h4);
        idle(9);
        exp_rd(16'h2); idle(1);
        exp_rd(16'h1); idle(1);
        idle(20);
        exp_rd(16'h1); rd(3'd0);
        wr(3'd4, 16'h0);
        exp_rd(16'd9); rd(3'd4);

        // START+STOP while stopped keeps RUN clear
        phase = 8'd5;
        wr(3'd1, 16'hC);
        exp_rd(16'h1); idle(1);
        wr(3'd0, 16'h0);

        // STOP holds the counter at 100
        phase = 8'd6;
        wr(3'd2, 16'd200);
        wr(3'd3, 16'h0);
        wr(3'd1, 16'h6);
        wait_count(32'd101);
        wr(3'd1, 16'hA);
        idle(5);
        exp_rd(16'h0); idle(1);
        wr(3'd4, 16'h0);
        exp_rd(16'd100); rd(3'd4);
        exp_rd(16'h0); rd(3'd5);

        // Period 0, continuous: timeout every clock, set beats clear
        phase = 8'd7;
        wr(3'd2, 16'h0);
        wr(3'd3, 16'h0);
        wr(3'd1, 16'h6);
        idle(3);
        exp_rd(16'h3); idle(1);
        wr(3'd0, 16'h0);
        exp_rd(16'h3); idle(1);

        // Full counter width: period 0x10000, borrow across the halves
        phase = 8'd8;
        wr(3'd1, 16'hA);
        wr(3'd2, 16'h0);
        wr(3'd3, 16'h1);
        idle(2);
        wr(3'd5, 16'h0);
        exp_rd(16'h1); rd(3'd5);
        exp_rd(16'h0); rd(3'd4);
        exp_rd(16'h1); rd(3'd3);
        wr(3'd1, 16'h6);
        idle(3);
        wr(3'd4, 16'h0);
        exp_rd(16'hFFFD); rd(3'd4);
        exp_rd(16'h0); rd(3'd5);

        // Reset mid-count with TO and ITO set
        phase = 8'd9;
        wr(3'd2, 16'd20);
        wr(3'd3, 16'h0);
        wr(3'd1, 16'h7);
        wait_count(32'd5);
        exp_irq(1'b1); idle(1);
        exp_rd(16'h0); exp_irq(1'b0);
        cycle(1'b0, 1'b1, 1'b1, 3'd2, 16'h0);
        wr(3'd4, 16'h0);
        exp_rd(16'd299); rd(3'd4);
        exp_rd(16'h0); rd(3'd0);
        exp_rd(16'd299); rd(3'd2);

        // Random traffic against the model
        phase = 8'd10;
        for (int i = 0; i < 4000; i++) begin
            bit          rn, cs, wn;
            logic [2:0]  a;
            logic [15:0] d;
            rn = ($urandom_range(0, 199) != 0);
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 1) != 0);
            a  = 3'($urandom_range(0, 7));
            case (a)
                3'd2:    d = 16'($urandom_range(0, 12));
                3'd3:    d = ($urandom_range(0, 15) == 0) ? 16'h1 : 16'h0;
                3'd1:    d = 16'($urandom_range(0, 15));
                default: d = 16'($urandom);
            endcase
            cycle(rn, cs, wn, a, d);
        end

        idle(2);
        @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_interval_timer_param.md
Name: avalon_interval_timer_param

Overview:
- Parametrised Avalon-MM interval timer, the next generation of the fixed-period top timer: configurable counter width and reset period, runtime-writable period, start/stop control, continuous or one-shot mode, and counter snapshot.
- Sits on the Nios II system bus as a small slave and drives one level-sensitive IRQ line to the processor.

Parameters:
- DATA_W, 16, Avalon data width; must be ≥ 4.
- COUNT_W, 32, counter width; DATA_W < COUNT_W ≤ 2*DATA_W.
- RESET_PERIOD, 62499, period load value after reset; timeout every RESET_PERIOD+1 clocks.
- ALWAYS_RUN, 0, 1 = counter runs from reset and STOP is ignored.
- RESET_CONT, 1, reset value of CONT (continuous mode).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  registered read data
- irq  out  1  interrupt request, level

Interface fixed: one clock (clk); reset is synchronous and active-low (reset_n). All state updates on posedge clk only; reset_n low at a rising edge resets all state.

Behaviour:
- Register map (wr = chipselect & ~write_n & address match):
  - 0 STATUS: read {RUN, TO} in bits [1:0]; any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START (write-1 strobe), bit3 STOP (write-1 strobe). Reads return {0,0,CONT,ITO}.
  - 2 PERIODL: period[DATA_W-1:0].
  - 3 PERIODH: period[COUNT_W-1:DATA_W], zero-extended on read.
  - 4 SNAPL: write captures counter into snap register; read returns snap low.
  - 5 SNAPH: write also captures; read returns snap high.
  - 6, 7: read 0, writes ignored.
- Reset values:
  - counter = period = RESET_PERIOD.
  - RUN = ALWAYS_RUN; TO = 0; ITO = 0; CONT = RESET_CONT.
  - snap = 0; readdata = 0; irq = 0.
- Counting: while RUN, counter decrements by 1 each clock.
- Timeout: when counter==0 and RUN:
  - next clock, counter reloads with period and TO sets.
  - If CONT=0, RUN also clears (one-shot); else counting continues.
  - Period N gives timeout every N+1 clocks; period 0 gives timeout every clock in continuous mode.
- Period write (addr 2 or 3):
  - updates the half register at that clock edge;
  - the following clock forces counter = new period (force_reload), regardless of RUN;
  - RUN is unchanged.
  - force_reload takes priority over decrement and over the timeout reload.
- START:
  - when RUN=0: sets RUN next clock and counts from the current counter value;
  - when RUN=1: no effect.
- STOP: clears RUN next clock; counter holds its value.
- START and STOP in the same write: STOP wins. With ALWAYS_RUN=1, STOP is ignored.
- TO priority: a timeout in the same clock as a STATUS write leaves TO=1 (set wins over clear).
- irq = TO & ITO, combinational from registers, so irq follows a CONTROL/STATUS write with 1 clock latency.
- readdata: registered read_mux(address), updated every clock independent of chipselect; read latency 1 clock.
- Snapshot captures the counter value present in the clock of the write. readdata reflects snap on the read issued after the capture write.
- Width: counter arithmetic is modulo 2^COUNT_W. Decrement is never applied at 0 (reload instead), so there is no wrap.
- Reset mid-count: all state returns to reset values at the next edge with reset_n=0. A pending force_reload is discarded.

Decomposition:
- Shared package avalon_timer_pkg:
  - register offsets (ADDR_STATUS..ADDR_SNAPH);
  - CONTROL/STATUS bit positions (BIT_ITO, BIT_CONT, BIT_START, BIT_STOP, BIT_TO, BIT_RUN).
- Sub-module timer_count_core (parameter COUNT_W), responsible for:
  - the counter register;
  - load/decrement/reload priority;
  - zero detect and timeout pulse.
- The top level holds the Avalon decode, control/status registers, snapshot and read mux.

Test Plan:
- Reset, then idle with RESET_PERIOD=62499, CONT=1, ALWAYS_RUN=1 → TO first rises 62500 clocks after reset release, then every 62500 clocks; irq stays 0 until CONTROL write 0x1, then irq=1 the next clock.
- Write PERIODL=9 and PERIODH=0, CONTROL=0x4 (one-shot, START) → counter reloads to 9; exactly one TO after 10 clocks; RUN=0 afterwards; STATUS read returns 0x1.
- STATUS write in the same clock as a timeout → TO remains 1. STATUS write the next clock → TO=0 and irq falls one clock later.
- CONTROL write 0xC (START+STOP) while stopped → RUN stays 0. STOP while running at counter 100 → counter holds 100; SNAPL write then read returns 100.
- Period 0 with CONT=1 → TO set every clock. COUNT_W=32: PERIODH=0x0001, PERIODL=0x0000 → timeout interval 65537 clocks.
- Assert reset_n low mid-count (counter 5) for 1 clock → counter=RESET_PERIOD, TO=0, readdata=0, irq=0 at the next edge.
